// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, per-register busy
// scoreboard and a sequenced bulk-clear engine for the pipelined datapath.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam bit                    HAS_ZERO  = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy;

  logic idle;
  logic wr_ok;
  logic rsv_ok;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return HAS_ZERO && (a == '0);
  endfunction

  assign idle   = (state == IDLE);
  assign wr_ok  = idle && wr_en  && !is_zero(wr_addr);
  assign rsv_ok = idle && rsv_en && !is_zero(rsv_addr);

  // Bypass only while IDLE: during a clear the incoming write is dropped,
  // so forwarding it would show a value that never lands.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    busy1    = busy[rd_addr1];
    if (is_zero(rd_addr1)) begin
      rd_data1 = '0;
      busy1    = 1'b0;
    end else if (idle && wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      busy1    = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = mem[rd_addr2];
    busy2    = busy[rd_addr2];
    if (is_zero(rd_addr2)) begin
      rd_data2 = '0;
      busy2    = 1'b0;
    end else if (idle && wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      busy2    = 1'b0;
    end
  end

  // NOTE: the storage array is reset along with the control state because
  // an asynchronous reset must return every register to zero immediately;
  // this makes it a flop array rather than an inferred RAM.
  // NOTE: sequential state uses non-blocking assignments only, so the later
  // reserve update to the same busy bit cleanly overrides the write's clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ok) begin
            mem[wr_addr]  <= wr_data;
            busy[wr_addr] <= 1'b0;
          end
          if (rsv_ok) begin
            busy[rsv_addr] <= 1'b1;
          end
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt]  <= '0;
          busy[cnt] <= 1'b0;
          // Hold the counter at the last address instead of wrapping.
          if (cnt == LAST_ADDR) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          busy1, busy2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          clr_req;
  logic          clr_busy, clr_done;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] model_mem  [DEPTH];
  bit            model_busy [DEPTH];

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .busy1    (busy1),
    .busy2    (busy2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // Reference model: what an IDLE-state read should return right now.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return model_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return model_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]  = '0;
      model_busy[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    clr_req  = 1'b0;
  endtask

  // Clock edge while IDLE: apply the write then the reserve to the model.
  task automatic tick();
    if (wr_en && wr_addr != 0) begin
      model_mem[wr_addr]  = wr_data;
      model_busy[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != 0) model_busy[rsv_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_regs();
    for (int a = 1; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = $urandom() | 32'h1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    rd_addr1 = '0;
    rd_addr2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy_in_reset: got %b expected 0", clr_busy); else passed++;
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a += 5) begin
      rd_addr1 = AW'(a);
      rd_addr2 = AW'(DEPTH - 1 - a);
      #1;
      total++; if (rd_data1 !== '0) $display("FAIL reset_rd1[%0d]: got %h expected 0", a, rd_data1); else passed++;
      total++; if (busy2 !== 1'b0) $display("FAIL reset_busy2[%0d]: got %b expected 0", DEPTH - 1 - a, busy2); else passed++;
    end
    total++; if (clr_done !== 1'b0) $display("FAIL reset_clr_done: got %b expected 0", clr_done); else passed++;
    cycle();
  endtask

  task automatic test_write_read();
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd_addr1 = 5'd5;
    #1;
    total++; if (rd_data1 !== 32'hDEADBEEF) $display("FAIL write_read_r5: got %h expected deadbeef", rd_data1); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL write_read_busy: got %b expected 0", busy1); else passed++;
  endtask

  task automatic test_zero_reg();
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'h12345678;
    rd_addr1 = 5'd0;
    #1;
    total++; if (rd_data1 !== '0) $display("FAIL zero_reg_bypass: got %h expected 0", rd_data1); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if (rd_data1 !== '0) $display("FAIL zero_reg_write: got %h expected 0", rd_data1); else passed++;
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    tick();
    idle_inputs();
    #1;
    total++; if (busy1 !== 1'b0) $display("FAIL zero_reg_reserve: got %b expected 0", busy1); else passed++;
  endtask

  task automatic test_bypass();
    rd_addr2 = 5'd7;
    #1;
    total++; if (rd_data2 !== '0) $display("FAIL bypass_r7_initial: got %h expected 0", rd_data2); else passed++;
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5A5A5;
    #1;
    total++; if (rd_data2 !== 32'hA5A5A5A5) $display("FAIL bypass_data: got %h expected a5a5a5a5", rd_data2); else passed++;
    total++; if (busy2 !== 1'b0) $display("FAIL bypass_busy: got %b expected 0", busy2); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if (rd_data2 !== 32'hA5A5A5A5) $display("FAIL bypass_stored: got %h expected a5a5a5a5", rd_data2); else passed++;
  endtask

  task automatic test_scoreboard();
    rd_addr1 = 5'd9;
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    tick();
    idle_inputs();
    #1;
    total++; if (busy1 !== 1'b1) $display("FAIL sb_reserve: got %b expected 1", busy1); else passed++;
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h55;
    #1;
    total++; if (busy1 !== 1'b0) $display("FAIL sb_arriving_not_busy: got %b expected 0", busy1); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if (busy1 !== 1'b0) $display("FAIL sb_write_clears: got %b expected 0", busy1); else passed++;
    total++; if (rd_data1 !== 32'h55) $display("FAIL sb_write_data: got %h expected 55", rd_data1); else passed++;
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h66;
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    tick();
    idle_inputs();
    #1;
    total++; if (busy1 !== 1'b1) $display("FAIL sb_reserve_wins: got %b expected 1", busy1); else passed++;
    total++; if (rd_data1 !== 32'h66) $display("FAIL sb_same_cycle_data: got %h expected 66", rd_data1); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 31));
      wr_data  = $urandom();
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 2) == 0) ? rsv_addr : AW'($urandom_range(0, 31));
      #1;
      total++; if (rd_data1 !== exp_rd(rd_addr1)) $display("FAIL rand_rd1 n=%0d a=%0d: got %h expected %h", n, rd_addr1, rd_data1, exp_rd(rd_addr1)); else passed++;
      total++; if (rd_data2 !== exp_rd(rd_addr2)) $display("FAIL rand_rd2 n=%0d a=%0d: got %h expected %h", n, rd_addr2, rd_data2, exp_rd(rd_addr2)); else passed++;
      total++; if (busy1 !== exp_busy(rd_addr1)) $display("FAIL rand_busy1 n=%0d a=%0d: got %b expected %b", n, rd_addr1, busy1, exp_busy(rd_addr1)); else passed++;
      total++; if (busy2 !== exp_busy(rd_addr2)) $display("FAIL rand_busy2 n=%0d a=%0d: got %b expected %b", n, rd_addr2, busy2, exp_busy(rd_addr2)); else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a);
      #1;
      total++; if (rd_data1 !== '0) $display("FAIL %s_rd[%0d]: got %h expected 0", tag, a, rd_data1); else passed++;
      total++; if (busy1 !== 1'b0) $display("FAIL %s_busy[%0d]: got %b expected 0", tag, a, busy1); else passed++;
    end
  endtask

  task automatic test_clear();
    int n;
    fill_regs();
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd20;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    total++; if (clr_busy !== 1'b1) $display("FAIL clear_start: got %b expected 1", clr_busy); else passed++;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      wr_en    = 1'b1;
      wr_addr  = AW'($urandom_range(1, 31));
      wr_data  = $urandom() | 32'h1;
      rsv_en   = 1'b1;
      rsv_addr = AW'($urandom_range(1, 31));
      cycle();
      n++;
    end
    total++; if (n !== DEPTH) $display("FAIL clear_busy_cycles: got %0d expected %0d", n, DEPTH); else passed++;
    total++; if (clr_done !== 1'b1) $display("FAIL clear_done_pulse: got %b expected 1", clr_done); else passed++;
    // Keep writing through the DONE cycle; those must be dropped too.
    wr_addr = 5'd1;
    rsv_addr = 5'd2;
    cycle();
    idle_inputs();
    total++; if (clr_done !== 1'b0) $display("FAIL clear_done_width: got %b expected 0", clr_done); else passed++;
    total++; if (clr_busy !== 1'b0) $display("FAIL clear_back_idle: got %b expected 0", clr_busy); else passed++;
    model_clear();
    check_all_zero("clear");
    cycle();
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    fill_regs();
    rd_addr1 = 5'd20;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) cycle();
    #3;
    reset = 1'b1;
    #1;
    total++; if (clr_busy !== 1'b0) $display("FAIL midclr_busy_drop: got %b expected 0", clr_busy); else passed++;
    total++; if (clr_done !== 1'b0) $display("FAIL midclr_done_in_reset: got %b expected 0", clr_done); else passed++;
    total++; if (rd_data1 !== '0) $display("FAIL midclr_async_r20: got %h expected 0", rd_data1); else passed++;
    @(posedge clk);
    #2;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (clr_done === 1'b1 || clr_busy === 1'b1) done_seen++;
    end
    total++; if (done_seen !== 0) $display("FAIL midclr_no_resume: got %0d active cycles expected 0", done_seen); else passed++;
    model_clear();
    check_all_zero("midclr");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
